// File: rtl/i2c_master_fsm_if.sv
// Bus bundle between the I2C master sequencer and its user / pad environment.
// Carries the quarter-phase data_clk from the SCL generator, the byte-level
// ena/busy command handshake and the open-drain SDA controls.
interface i2c_master_fsm_if;
  logic       data_clk;
  logic       ena;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_wr;
  logic       sda_i;
  logic       sda_o;
  logic       scl_not_ena;
  logic       busy;
  logic [7:0] data_rd;
  logic       ack_error;

  modport master (
    input  data_clk, ena, addr, rw, data_wr, sda_i,
    output sda_o, scl_not_ena, busy, data_rd, ack_error
  );

  modport slave (
    output data_clk, ena, addr, rw, data_wr, sda_i,
    input  sda_o, scl_not_ena, busy, data_rd, ack_error
  );
endinterface

// File: rtl/i2c_master_fsm.sv
// I2C master byte/transaction sequencer. Advances one SDA bit per data_clk
// period: data bits change on data_clk rise (SCL low), start/stop conditions
// are produced on data_clk fall (SCL high). Handles address/RW, write, read,
// ACK/NACK, repeated start and stop under an ena/busy command handshake.
module i2c_master_fsm (
  input  logic               clk,
  input  logic               rst,
  i2c_master_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    READY, START, COMMAND, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
  } state_t;

  state_t     state_q, state_d;
  logic       prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] addr_rw_q, addr_rw_d;
  logic [7:0] data_tx_q, data_tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] data_rd_q, data_rd_d;
  logic       busy_q, busy_d;
  logic       ack_error_q, ack_error_d;
  logic       sda_q, sda_d;
  logic       scl_not_ena_q, scl_not_ena_d;

  logic       rise_edge;
  logic       fall_edge;
  logic [7:0] cmd_addr_rw;

  assign rise_edge   = bus.data_clk & ~prev_q;
  assign fall_edge   = ~bus.data_clk & prev_q;
  assign cmd_addr_rw = {bus.addr, bus.rw};

  // Next-state and register updates, applied only on detected data_clk edges
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    addr_rw_d     = addr_rw_q;
    data_tx_d     = data_tx_q;
    rx_d          = rx_q;
    data_rd_d     = data_rd_q;
    busy_d        = busy_q;
    ack_error_d   = ack_error_q;
    sda_d         = sda_q;
    scl_not_ena_d = scl_not_ena_q;

    if (rise_edge) begin
      case (state_q)
        READY: begin
          if (bus.ena) begin
            addr_rw_d   = cmd_addr_rw;
            data_tx_d   = bus.data_wr;
            busy_d      = 1'b1;
            ack_error_d = 1'b0;
            state_d     = START;
          end else begin
            busy_d = 1'b0;
            sda_d  = 1'b1;
          end
        end
        START: begin
          sda_d     = addr_rw_q[7];
          bit_cnt_d = 3'd7;
          state_d   = COMMAND;
        end
        COMMAND: begin
          if (bit_cnt_q == 3'd0) begin
            sda_d     = 1'b1;
            bit_cnt_d = 3'd7;
            state_d   = SLV_ACK1;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            sda_d     = addr_rw_q[bit_cnt_q - 3'd1];
          end
        end
        SLV_ACK1: begin
          if (!addr_rw_q[0]) begin
            sda_d   = data_tx_q[7];
            state_d = WR;
          end else begin
            sda_d   = 1'b1;
            state_d = RD;
          end
        end
        WR: begin
          busy_d = 1'b1;
          if (bit_cnt_q == 3'd0) begin
            sda_d     = 1'b1;
            bit_cnt_d = 3'd7;
            state_d   = SLV_ACK2;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            sda_d     = data_tx_q[bit_cnt_q - 3'd1];
          end
        end
        RD: begin
          busy_d = 1'b1;
          if (bit_cnt_q == 3'd0) begin
            data_rd_d = rx_q;
            bit_cnt_d = 3'd7;
            state_d   = MSTR_ACK;
            // ACK only if the user is continuing the same read
            sda_d     = (bus.ena && (cmd_addr_rw == addr_rw_q)) ? 1'b0 : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        SLV_ACK2, MSTR_ACK: begin
          if (bus.ena) begin
            busy_d    = 1'b0;
            addr_rw_d = cmd_addr_rw;
            data_tx_d = bus.data_wr;
            if (cmd_addr_rw == addr_rw_q) begin
              if (!bus.rw) begin
                sda_d   = bus.data_wr[7];
                state_d = WR;
              end else begin
                sda_d   = 1'b1;
                state_d = RD;
              end
            end else begin
              // Release SDA now so START can pull it low while SCL is high
              sda_d   = 1'b1;
              state_d = START;
            end
          end else begin
            sda_d   = 1'b0;
            state_d = STOP;
          end
        end
        STOP: begin
          busy_d  = 1'b0;
          state_d = READY;
        end
        default: begin
          state_d = READY;
        end
      endcase
    end else if (fall_edge) begin
      case (state_q)
        START: begin
          sda_d         = 1'b0;
          scl_not_ena_d = 1'b0;
        end
        SLV_ACK1, SLV_ACK2: begin
          if (bus.sda_i) begin
            ack_error_d = 1'b1;
          end
        end
        RD: begin
          rx_d[bit_cnt_q] = bus.sda_i;
        end
        STOP: begin
          sda_d         = 1'b1;
          scl_not_ena_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over edge actions
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= READY;
      prev_q        <= 1'b0;
      bit_cnt_q     <= 3'd7;
      addr_rw_q     <= 8'd0;
      data_tx_q     <= 8'd0;
      rx_q          <= 8'd0;
      data_rd_q     <= 8'd0;
      busy_q        <= 1'b0;
      ack_error_q   <= 1'b0;
      sda_q         <= 1'b1;
      scl_not_ena_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      prev_q        <= bus.data_clk;
      bit_cnt_q     <= bit_cnt_d;
      addr_rw_q     <= addr_rw_d;
      data_tx_q     <= data_tx_d;
      rx_q          <= rx_d;
      data_rd_q     <= data_rd_d;
      busy_q        <= busy_d;
      ack_error_q   <= ack_error_d;
      sda_q         <= sda_d;
      scl_not_ena_q <= scl_not_ena_d;
    end
  end

  assign bus.sda_o       = sda_q;
  assign bus.scl_not_ena = scl_not_ena_q;
  assign bus.busy        = busy_q;
  assign bus.data_rd     = data_rd_q;
  assign bus.ack_error   = ack_error_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed testbench for i2c_master_fsm. A free-running data_clk source (with
// a stretch hold), a bus monitor that records the SDA line at every data_clk
// fall while SCL is active (S = start, P = stop, 0/1 = data), and a small
// responsive slave that ACKs and returns read data on the open-drain line.
module tb_i2c_master_fsm;

  logic clk = 1'b0;
  logic rst;
  i2c_master_fsm_if bus ();

  i2c_master_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    mark     = 0;
  string trace    = "";

  logic       stretch  = 1'b0;
  logic       ack_en   = 1'b1;
  logic [7:0] rd_byte0 = 8'h00;
  logic [7:0] rd_byte1 = 8'h00;
  logic [2:0] qcnt     = 3'd0;

  logic mon_prev    = 1'b0;
  logic fall_seen   = 1'b0;
  logic before_line = 1'b1;
  logic before_scl  = 1'b1;
  logic slave_sda   = 1'b1;
  logic in_frame    = 1'b0;
  logic quiet       = 1'b0;
  logic s_rw        = 1'b0;
  int   sidx        = 0;
  logic sda_line;

  logic       snap_sda;
  int         snap_len;

  // data_clk source: 8 system clocks per bit, high for the middle four
  always @(posedge clk) begin
    if (!stretch) qcnt <= qcnt + 3'd1;
  end

  assign bus.data_clk = qcnt[2] ^ qcnt[1];
  assign sda_line     = bus.sda_o & slave_sda;
  assign bus.sda_i    = sda_line;

  function automatic string bitChar(input logic b);
    return b ? "1" : "0";
  endfunction

  function automatic logic slaveBit(input logic fr, input logic q, input int idx,
                                    input logic rwb, input logic acken,
                                    input logic [7:0] b0, input logic [7:0] b1);
    int         pos;
    int         n;
    logic [7:0] sel;
    if (!fr || q) return 1'b1;
    if (idx == 8) return !acken;
    if (idx < 9) return 1'b1;
    pos = (idx - 9) % 9;
    n   = (idx - 9) / 9;
    if (pos == 8) return rwb ? 1'b1 : !acken;
    if (!rwb) return 1'b1;
    sel = (n == 0) ? b0 : ((n == 1) ? b1 : 8'hFF);
    return sel[3'(7 - pos)];
  endfunction

  // Bus monitor and slave: log SDA at each fall while SCL runs, drive at rises
  always @(posedge clk) begin
    mon_prev <= bus.data_clk;
    if (rst) begin
      fall_seen <= 1'b0;
      in_frame  <= 1'b0;
      quiet     <= 1'b0;
      slave_sda <= 1'b1;
    end else begin
      if (fall_seen) begin
        fall_seen <= 1'b0;
        if (!before_scl || !bus.scl_not_ena) begin
          if (before_line && !sda_line) begin
            trace    <= {trace, "S"};
            sidx     <= 0;
            in_frame <= 1'b1;
            quiet    <= 1'b0;
          end else if (!before_line && sda_line) begin
            trace    <= {trace, "P"};
            in_frame <= 1'b0;
          end else begin
            trace <= {trace, bitChar(sda_line)};
            if (sidx == 7) s_rw <= sda_line;
            if (s_rw && sidx >= 9 && ((sidx - 9) % 9) == 8 && sda_line) quiet <= 1'b1;
            sidx <= sidx + 1;
          end
        end
      end
      if (!bus.data_clk && mon_prev) begin
        fall_seen   <= 1'b1;
        before_line <= sda_line;
        before_scl  <= bus.scl_not_ena;
      end
      if (bus.data_clk && !mon_prev) begin
        slave_sda <= slaveBit(in_frame, quiet, sidx, s_rw, ack_en, rd_byte0, rd_byte1);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkTrace(input string tag, input string expected);
    string got;
    got = trace.substr(mark, trace.len() - 1);
    n_checks++;
    assert (got == expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%s expected=%s", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [6:0] a, input logic r,
                               input logic [7:0] d);
    @(negedge clk);
    bus.ena     = e;
    bus.addr    = a;
    bus.rw      = r;
    bus.data_wr = d;
  endtask

  task automatic waitBusy(input logic level, input string tag);
    for (int i = 0; i < 2000 && bus.busy !== level; i++) @(negedge clk);
    checkOutput(tag, 32'(bus.busy), 32'(level));
  endtask

  task automatic waitTrace(input int n, input string tag);
    for (int i = 0; i < 2000 && trace.len() < n; i++) @(negedge clk);
    checkOutput(tag, 32'(trace.len() >= n), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    bus.ena     = 1'b0;
    bus.addr    = 7'h00;
    bus.rw      = 1'b0;
    bus.data_wr = 8'h00;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sda_o", 32'(bus.sda_o), 32'd1);
    checkOutput("rst_scl_not_ena", 32'(bus.scl_not_ena), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_ack_error", 32'(bus.ack_error), 32'd0);
    checkOutput("rst_data_rd", 32'(bus.data_rd), 32'h00);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("idle_sda_o", 32'(bus.sda_o), 32'd1);
    checkOutput("idle_scl_not_ena", 32'(bus.scl_not_ena), 32'd1);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_no_bus_events", 32'(trace.len()), 32'd0);

    // Single write 0x50 <- 0xA5 with slave ACKs
    $display("[TB] write 0x50 <- 0xA5");
    mark = trace.len();
    applyStimulus(1'b1, 7'h50, 1'b0, 8'hA5);
    waitBusy(1'b1, "wr_busy_rise");
    applyStimulus(1'b0, 7'h50, 1'b0, 8'hA5);
    waitBusy(1'b0, "wr_busy_fall");
    checkTrace("wr_trace", "S101000000101001010P");
    checkOutput("wr_ack_error", 32'(bus.ack_error), 32'd0);
    checkOutput("wr_end_sda_o", 32'(bus.sda_o), 32'd1);
    checkOutput("wr_end_scl_not_ena", 32'(bus.scl_not_ena), 32'd1);

    // Same write with no slave present: sticky ack_error
    $display("[TB] write with NACK");
    ack_en = 1'b0;
    mark = trace.len();
    applyStimulus(1'b1, 7'h50, 1'b0, 8'hA5);
    waitBusy(1'b1, "nack_busy_rise");
    checkOutput("nack_ack_error_pre", 32'(bus.ack_error), 32'd0);
    applyStimulus(1'b0, 7'h50, 1'b0, 8'hA5);
    waitTrace(mark + 10, "nack_reach_ack1");
    checkOutput("nack_ack_error_ack1", 32'(bus.ack_error), 32'd1);
    waitBusy(1'b0, "nack_busy_fall");
    checkTrace("nack_trace", "S101000001101001011P");
    checkOutput("nack_ack_error_end", 32'(bus.ack_error), 32'd1);

    // Single read from 0x51, slave returns 0x3C, master NACKs
    $display("[TB] read 0x51 -> 0x3C");
    ack_en   = 1'b1;
    rd_byte0 = 8'h3C;
    mark = trace.len();
    applyStimulus(1'b1, 7'h51, 1'b1, 8'h00);
    waitBusy(1'b1, "rd_busy_rise");
    checkOutput("rd_ack_error_cleared", 32'(bus.ack_error), 32'd0);
    applyStimulus(1'b0, 7'h51, 1'b1, 8'h00);
    waitBusy(1'b0, "rd_busy_fall");
    checkTrace("rd_trace", "S101000110001111001P");
    checkOutput("rd_data_rd", 32'(bus.data_rd), 32'h3C);
    checkOutput("rd_ack_error", 32'(bus.ack_error), 32'd0);

    // Continued write, repeated start, two-byte read with master ACK
    $display("[TB] continuation and repeated start");
    rd_byte0 = 8'h96;
    rd_byte1 = 8'h4B;
    mark = trace.len();
    applyStimulus(1'b1, 7'h50, 1'b0, 8'h11);
    waitBusy(1'b1, "cont_busy_first");
    applyStimulus(1'b1, 7'h50, 1'b0, 8'h22);
    waitBusy(1'b0, "cont_accept_second");
    waitBusy(1'b1, "cont_busy_second");
    applyStimulus(1'b1, 7'h51, 1'b1, 8'h22);
    waitBusy(1'b0, "cont_accept_restart");
    waitBusy(1'b1, "cont_busy_read1");
    waitBusy(1'b0, "cont_accept_read2");
    checkOutput("cont_data_rd_first", 32'(bus.data_rd), 32'h96);
    waitBusy(1'b1, "cont_busy_read2");
    applyStimulus(1'b0, 7'h51, 1'b1, 8'h22);
    waitBusy(1'b0, "cont_busy_end");
    checkTrace("cont_trace", "S101000000000100010001000100S101000110100101100010010111P");
    checkOutput("cont_data_rd_second", 32'(bus.data_rd), 32'h4B);
    checkOutput("cont_ack_error", 32'(bus.ack_error), 32'd0);

    // Clock stretch during a write, then reset mid-write
    $display("[TB] stretch and reset");
    mark = trace.len();
    applyStimulus(1'b1, 7'h50, 1'b0, 8'hC3);
    waitBusy(1'b1, "st_busy_rise");
    applyStimulus(1'b0, 7'h50, 1'b0, 8'hC3);
    waitTrace(mark + 12, "st_reach_wr");
    for (int i = 0; i < 20 && bus.data_clk !== 1'b1; i++) @(negedge clk);
    checkOutput("st_data_clk_high", 32'(bus.data_clk), 32'd1);
    stretch = 1'b1;
    repeat (2) @(negedge clk);
    snap_sda = bus.sda_o;
    snap_len = trace.len();
    repeat (50) @(negedge clk);
    checkOutput("st_sda_held", 32'(bus.sda_o), 32'(snap_sda));
    checkOutput("st_no_new_bits", 32'(trace.len()), 32'(snap_len));
    checkOutput("st_busy_held", 32'(bus.busy), 32'd1);
    checkOutput("st_scl_active", 32'(bus.scl_not_ena), 32'd0);
    stretch = 1'b0;
    waitTrace(mark + 14, "st_resume");
    checkTrace("st_partial_trace", "S1010000001100");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_sda_o", 32'(bus.sda_o), 32'd1);
    checkOutput("mid_rst_scl_not_ena", 32'(bus.scl_not_ena), 32'd1);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    snap_len = trace.len();
    repeat (30) @(negedge clk);
    checkOutput("mid_rst_no_stop", 32'(trace.len()), 32'(snap_len));

    mark = trace.len();
    applyStimulus(1'b1, 7'h50, 1'b0, 8'h5A);
    waitBusy(1'b1, "post_rst_busy_rise");
    applyStimulus(1'b0, 7'h50, 1'b0, 8'h5A);
    waitBusy(1'b0, "post_rst_busy_fall");
    checkTrace("post_rst_trace", "S101000000010110100P");
    checkOutput("post_rst_ack_error", 32'(bus.ack_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
